// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Integer register file with a per-register pending-write scoreboard.
//   One write port fed by the writeback stage, two combinational read ports
//   for decode, with same-cycle bypass of writeback data onto the read ports.
//   Decode is stalled when it reads a register whose producer has not reached
//   writeback yet, or when a new writer would overflow the destination counter.
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   id_issue, id_rs1, id_rs2,
//   id_rd, id_reg_write          decode-side issue request and operands
//   rs1_data, rs2_data           combinational read data (x0 reads 0)
//   stall                        issue blocked this cycle
//   wb_alu_result, wb_rd,
//   wb_reg_write                 writeback port
module register_file_scoreboard #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_issue,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Combinational views of per-register state; index 0 is tied off so that
  // x0 reads 0, is never pending and never sees a writeback hit.
  logic [XLEN-1:0]      data_view [0:31];
  logic [CNT_WIDTH-1:0] cnt_view  [0:31];
  logic [31:0]          wb_hit;
  logic [31:0]          inc_vec;
  logic [31:0]          dec_vec;
  logic [31:0]          pending_vec;

  assign data_view[0]   = '0;
  assign cnt_view[0]    = '0;
  assign wb_hit[0]      = 1'b0;
  assign inc_vec[0]     = 1'b0;
  assign dec_vec[0]     = 1'b0;
  assign pending_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [XLEN-1:0]      data_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;

      assign wb_hit[gi]  = wb_reg_write && (wb_rd == 5'(gi));
      // A writeback to an idle register still writes data but must not
      // underflow the counter.
      assign dec_vec[gi] = wb_hit[gi] && (cnt_reg != '0);
      assign inc_vec[gi] = id_issue && !stall && id_reg_write && (id_rd == 5'(gi));
      // The producer retiring this cycle is served by the bypass.
      assign pending_vec[gi] = (cnt_reg - CNT_WIDTH'(dec_vec[gi])) != '0;

      assign data_view[gi] = data_reg;
      assign cnt_view[gi]  = cnt_reg;

      always_comb begin
        cnt_next = cnt_reg;
        if (inc_vec[gi] && !dec_vec[gi]) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (dec_vec[gi] && !inc_vec[gi]) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (wb_hit[gi]) begin
            data_reg <= wb_alu_result;
          end
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // Read ports: x0 -> 0, then writeback bypass, then storage.
  always_comb begin
    rs1_data = data_view[id_rs1];
    if (wb_hit[id_rs1]) begin
      rs1_data = wb_alu_result;
    end
    rs2_data = data_view[id_rs2];
    if (wb_hit[id_rs2]) begin
      rs2_data = wb_alu_result;
    end
  end

  logic waw_full;

  // WAW limit: a further writer would overflow the destination counter
  // unless one writer retires in the same cycle.
  assign waw_full = id_reg_write && (id_rd != 5'd0) &&
                    (cnt_view[id_rd] == CNT_MAX) && !dec_vec[id_rd];

  assign stall = id_issue &&
                 (pending_vec[id_rs1] || pending_vec[id_rs2] || waw_full);

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_issue;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  int checks_count   = 0;
  int failures_count = 0;

  register_file_scoreboard #(.XLEN(32), .CNT_WIDTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .id_issue      (id_issue),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .stall         (stall),
    .wb_alu_result (wb_alu_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks_count++;
    if (got !== exp) begin
      failures_count++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s value=%h", tag, got);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_issue      = 1'b0;
    id_rs1        = 5'd0;
    id_rs2        = 5'd0;
    id_rd         = 5'd0;
    id_reg_write  = 1'b0;
    wb_alu_result = 32'h0;
    wb_rd         = 5'd0;
    wb_reg_write  = 1'b0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    id_issue     = 1'b1;
    id_reg_write = 1'b1;
    id_rd        = rd;
    id_rs1       = 5'd0;
    id_rs2       = 5'd0;
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    wb_reg_write  = 1'b1;
    wb_rd         = rd;
    wb_alu_result = data;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // A writeback during reset must be discarded.
    #1;
    writeback(5'd4, 32'h44);
    step();
    step();
    reset = 1'b0;
    idle_inputs();
    #1;

    // T1: all registers zero, no stall even while issuing reads.
    id_issue = 1'b1;
    for (int r = 1; r < 32; r++) begin
      id_rs1 = 5'(r);
      id_rs2 = 5'(32 - r);
      #1;
      check_value($sformatf("t1_rs1_x%0d", r), rs1_data, 32'h0);
      check_value($sformatf("t1_rs2_x%0d", 32 - r), rs2_data, 32'h0);
      check_value($sformatf("t1_stall_x%0d", r), {31'b0, stall}, 32'h0);
    end
    idle_inputs();
    step();

    // T2: write x5 with same-cycle bypass, then read from storage.
    writeback(5'd5, 32'hDEADBEEF);
    id_rs1 = 5'd5;
    #1;
    check_value("t2_bypass_rs1", rs1_data, 32'hDEADBEEF);
    step();
    wb_reg_write = 1'b0;
    wb_alu_result = 32'h0;
    id_rs2 = 5'd5;
    #1;
    check_value("t2_stored_rs1", rs1_data, 32'hDEADBEEF);
    check_value("t2_stored_rs2", rs2_data, 32'hDEADBEEF);
    idle_inputs();
    step();

    // T3: x0 writes and issues ignored.
    writeback(5'd0, 32'h1234);
    issue_rd(5'd0);
    #1;
    check_value("t3_rs1_x0", rs1_data, 32'h0);
    check_value("t3_stall", {31'b0, stall}, 32'h0);
    step();
    idle_inputs();
    id_issue = 1'b1;
    #1;
    check_value("t3_x0_not_pending", {31'b0, stall}, 32'h0);
    check_value("t3_rs2_x0", rs2_data, 32'h0);
    idle_inputs();
    step();

    // T4: RAW hazard on x7.
    issue_rd(5'd7);
    #1;
    check_value("t4_first_issue_stall", {31'b0, stall}, 32'h0);
    step();
    idle_inputs();
    id_rs2 = 5'd7;
    #1;
    check_value("t4_no_issue_no_stall", {31'b0, stall}, 32'h0);
    id_issue = 1'b1;
    #1;
    check_value("t4_raw_stall", {31'b0, stall}, 32'h1);
    step();
    check_value("t4_raw_stall_hold", {31'b0, stall}, 32'h1);
    writeback(5'd7, 32'h55);
    #1;
    check_value("t4_wb_stall", {31'b0, stall}, 32'h0);
    check_value("t4_wb_rs2", rs2_data, 32'h55);
    step();
    wb_reg_write = 1'b0;
    wb_alu_result = 32'h0;
    #1;
    check_value("t4_after_stall", {31'b0, stall}, 32'h0);
    check_value("t4_after_rs2", rs2_data, 32'h55);
    idle_inputs();
    step();

    // T5: WAW limit on x3.
    for (int i = 0; i < 3; i++) begin
      issue_rd(5'd3);
      #1;
      check_value($sformatf("t5_issue%0d_stall", i), {31'b0, stall}, 32'h0);
      step();
    end
    issue_rd(5'd3);
    #1;
    check_value("t5_waw_stall", {31'b0, stall}, 32'h1);
    step();
    check_value("t5_waw_stall_hold", {31'b0, stall}, 32'h1);
    writeback(5'd3, 32'h31);
    #1;
    check_value("t5_waw_with_wb", {31'b0, stall}, 32'h0);
    step();
    wb_reg_write = 1'b0;
    #1;
    // Count stayed at 3, so the limit still applies.
    check_value("t5_cnt_still_full", {31'b0, stall}, 32'h1);
    idle_inputs();
    id_issue = 1'b1;
    id_rs1 = 5'd3;
    #1;
    check_value("t5_raw_x3", {31'b0, stall}, 32'h1);
    id_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      writeback(5'd3, 32'h32 + 32'(i));
      step();
    end
    wb_reg_write = 1'b0;
    id_issue = 1'b1;
    #1;
    check_value("t5_drained_stall", {31'b0, stall}, 32'h0);
    check_value("t5_drained_rs1", rs1_data, 32'h34);
    // Extra writeback on an idle register: data written, no underflow.
    id_issue = 1'b0;
    writeback(5'd3, 32'h77);
    step();
    wb_reg_write = 1'b0;
    id_issue = 1'b1;
    #1;
    check_value("t5_no_underflow_stall", {31'b0, stall}, 32'h0);
    check_value("t5_no_underflow_rs1", rs1_data, 32'h77);
    idle_inputs();
    step();

    // T6: reset discards pending counts and data.
    writeback(5'd9, 32'h99);
    step();
    idle_inputs();
    issue_rd(5'd9);
    step();
    step();
    idle_inputs();
    id_issue = 1'b1;
    id_rs1 = 5'd9;
    #1;
    check_value("t6_pending_before_reset", {31'b0, stall}, 32'h1);
    check_value("t6_data_before_reset", rs1_data, 32'h99);
    id_issue = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    id_issue = 1'b1;
    id_rs2 = 5'd4;
    #1;
    check_value("t6_stall_after_reset", {31'b0, stall}, 32'h0);
    check_value("t6_rs1_after_reset", rs1_data, 32'h0);
    check_value("t6_wb_during_reset_x4", rs2_data, 32'h0);
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_count, failures_count);
    $finish;
  end

endmodule
